dm_wait_responder: RTL and testbench

//  Data-memory responder: the slave end of the pipeline's load/store port.
//  - Accepts one request at a time over a req/gnt handshake.
//  - Inserts WAIT_CYCLES wait states, then returns read data or a write ack over rvalid/rready.
//  - Replaces the zero-latency data memory so the MEM stage can be tested under stall conditions.

---
 rtl/dm_pkg.sv | 21 ++
 rtl/dm_byte_array.sv | 26 ++
 rtl/dm_wait_responder.sv | 142 ++++++++++++++
 tb/tb_dm_wait_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory wait-state responder.
package dm_pkg;

  localparam int unsigned DM_WAIT_W = 4;
  localparam int unsigned DM_DATA_W = 32;
  localparam int unsigned DM_BE_W   = 4;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  // Request fields latched at accept time.
  typedef struct packed {
    logic                 we;
    logic [DM_BE_W-1:0]   be;
    logic [DM_DATA_W-1:0] wdata;
  } dm_req_t;

endpackage

// File: rtl/dm_byte_array.sv
// Word-organised storage with per-byte write enables; synchronous write, combinational read.
module dm_byte_array
  import dm_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic                 clk,
  input  logic [DM_BE_W-1:0]   wr_be,
  input  logic [AW-1:0]        addr,
  input  logic [DM_DATA_W-1:0] wdata,
  output logic [DM_DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [DM_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DM_BE_W); i++) begin
      if (wr_be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata_c = mem_q[addr];

endmodule

// File: rtl/dm_wait_responder.sv
// Load/store slave with programmable wait states and a held rvalid/rready response.
// Optional DM_ALIGN_CHECK_EN: misaligned requests skip the array and respond with err=1.
module dm_wait_responder
  import dm_pkg::*;
#(
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        gnt,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic        err
);

  dm_state_e             state_q, state_d;
  logic [DM_WAIT_W-1:0]  cnt_q, cnt_d;
  dm_req_t               req_q, req_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic                  gnt_q, gnt_d;
  logic                  rvalid_q, rvalid_d;
  logic [DM_DATA_W-1:0]  rdata_q, rdata_d;
  logic [DM_BE_W-1:0]    arr_be_c;
  logic [DM_DATA_W-1:0]  arr_rdata_c;
  logic                  misal_c;

  dm_byte_array #(.AW(AW)) u_array (
    .clk     (clk),
    .wr_be   (arr_be_c),
    .addr    (waddr_q),
    .wdata   (req_q.wdata),
    .rdata_c (arr_rdata_c)
  );

`ifdef DM_ALIGN_CHECK_EN
  logic misal_q, misal_d;
  logic err_q, err_d;
  logic unused_c;

  assign unused_c = ^addr[31:AW+2];
  assign misal_c  = misal_q;
  assign err      = err_q;

  // err follows rdata: loaded on RESP entry, cleared on RESP exit.
  always_comb begin
    misal_d = misal_q;
    err_d   = err_q;
    if (state_q == DM_IDLE && req) misal_d = (addr[1:0] != 2'b00);
    if (state_q == DM_WAIT && cnt_q == '0) err_d = misal_q;
    else if (state_q == DM_RESP && rvalid_q && rready) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misal_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      misal_q <= misal_d;
      err_q   <= err_d;
    end
  end
`else
  logic unused_c;

  assign unused_c = ^{addr[31:AW+2], addr[1:0]};
  assign misal_c  = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    waddr_d  = waddr_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    arr_be_c = '0;
    unique case (state_q)
      DM_IDLE: begin
        if (req) begin
          req_d   = '{we: we, be: be, wdata: wdata};
          waddr_d = addr[AW+1:2];
          cnt_d   = DM_WAIT_W'(WAIT_CYCLES);
          state_d = DM_WAIT;
        end
      end
      DM_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DM_WAIT_W'(1);
        end else begin
          state_d = DM_RESP;
          if (misal_c || req_q.we) rdata_d = '0;
          else                     rdata_d = arr_rdata_c;
          if (!misal_c && req_q.we) arr_be_c = req_q.be;
        end
      end
      // rvalid rises one cycle after entry; the handshake only counts once it is visible.
      DM_RESP: begin
        rvalid_d = 1'b1;
        if (rvalid_q && rready) begin
          rvalid_d = 1'b0;
          rdata_d  = '0;
          state_d  = DM_IDLE;
        end
      end
      default: state_d = DM_IDLE;
    endcase
    gnt_d = (state_d == DM_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DM_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      waddr_q  <= '0;
      gnt_q    <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      waddr_q  <= waddr_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dm_wait_responder.sv
// Scoreboard bench for dm_wait_responder: expected responses queued at issue, popped at rvalid.
module tb_dm_wait_responder;

  localparam int unsigned AW   = 10;
  localparam int unsigned WAIT = 2;
  localparam int          LAT  = int'(WAIT) + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        rready = 1'b1;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [int unsigned];

  dm_wait_responder #(.AW(AW), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .gnt(gnt), .rvalid(rvalid), .rready(rready), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int unsigned widx(input logic [31:0] a);
    return 32'(a[AW+1:2]);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model.exists(widx(a))) return model[widx(a)];
    return 32'h0;
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] w;
    w = model_rd(a);
    for (int i = 0; i < 4; i++) if (b[i]) w[8*i +: 8] = d[8*i +: 8];
    model[widx(a)] = w;
  endtask

  // Issues one request (called #1 after a clock edge) and returns once rvalid is seen.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, output logic [31:0] rd, output logic e,
                         output int lat);
    int g;
    g = 0;
    while (gnt !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
    checks++;
    if (gnt !== 1'b1) begin errors++; $display("FAIL gnt_wait: gnt=%b required 1", gnt); end
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
    lat = 0;
    while (rvalid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = rdata;
    e  = err;
  endtask

  task automatic finish_resp();
    rready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (gnt !== 1'b1)     begin errors++; $display("FAIL rst_gnt: got %b want 1", gnt); end
    if (rvalid !== 1'b0)  begin errors++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
    if (rdata !== 32'h0)  begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    if (err !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (gnt !== 1'b1)     begin errors++; $display("FAIL rel_gnt: got %b want 1", gnt); end
    if (rvalid !== 1'b0)  begin errors++; $display("FAIL rel_rvalid: got %b want 0", rvalid); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic e; int lat; exp_t ex;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    model_wr(32'h10, 32'hDEADBEEF, 4'hF);
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    ex = exp_q.pop_front();
    checks += 3;
    if (lat != LAT)      begin errors++; $display("FAIL store_lat: got %0d want %0d", lat, LAT); end
    if (rd !== ex.rdata) begin errors++; $display("FAIL store_rdata: got %h want %h", rd, ex.rdata); end
    if (e !== ex.err)    begin errors++; $display("FAIL store_err: got %b want %b", e, ex.err); end
    finish_resp();
    checks++;
    if (rvalid !== 1'b0 || gnt !== 1'b1)
      begin errors++; $display("FAIL store_release: rvalid=%b gnt=%b want 0/1", rvalid, gnt); end
    exp_q.push_back('{rdata: model_rd(32'h10), err: 1'b0});
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    ex = exp_q.pop_front();
    checks += 3;
    if (lat != LAT)      begin errors++; $display("FAIL load_lat: got %0d want %0d", lat, LAT); end
    if (rd !== ex.rdata) begin errors++; $display("FAIL load_rdata: got %h want %h", rd, ex.rdata); end
    if (e !== ex.err)    begin errors++; $display("FAIL load_err: got %b want %b", e, ex.err); end
    finish_resp();
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL load_clear: rdata=%h want 0", rdata); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic e; int lat; exp_t ex;
    logic [31:0] a [5] = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h20};
    logic [31:0] d [5] = '{32'hDEADBEEF, 32'h11223344, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic [3:0]  b [5] = '{4'hF, 4'b0101, 4'h0, 4'b0000, 4'h0};
    logic        w [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      if (w[i]) begin
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        model_wr(a[i], d[i], b[i]);
      end else begin
        exp_q.push_back('{rdata: model_rd(a[i]), err: 1'b0});
      end
      run_txn(w[i], a[i], d[i], b[i], rd, e, lat);
      ex = exp_q.pop_front();
      checks += 2;
      if (rd !== ex.rdata) begin errors++; $display("FAIL be_rdata[%0d]: got %h want %h", i, rd, ex.rdata); end
      if (e !== ex.err)    begin errors++; $display("FAIL be_err[%0d]: got %b want %b", i, e, ex.err); end
      finish_resp();
    end
    checks++;
    if (model_rd(32'h20) !== 32'hDE22BE44)
      begin errors++; $display("FAIL be_model: got %h want DE22BE44", model_rd(32'h20)); end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] rd; logic e; int lat; exp_t ex;
    model_wr(32'h8000_1060, 32'hA5A5_0001, 4'hF);
    run_txn(1'b1, 32'h8000_1060, 32'hA5A5_0001, 4'hF, rd, e, lat);
    finish_resp();
    exp_q.push_back('{rdata: 32'hA5A5_0001, err: 1'b0});
    run_txn(1'b0, 32'h60, 32'h0, 4'h0, rd, e, lat);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex.rdata) begin errors++; $display("FAIL wrap_rdata: got %h want %h", rd, ex.rdata); end
    finish_resp();
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic e; int lat; exp_t ex;
    rready = 1'b0;
    exp_q.push_back('{rdata: model_rd(32'h10), err: 1'b0});
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex.rdata) begin errors++; $display("FAIL bp_rdata: got %h want %h", rd, ex.rdata); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks += 3;
      if (rvalid !== 1'b1)  begin errors++; $display("FAIL bp_hold_rvalid[%0d]: got %b want 1", i, rvalid); end
      if (rdata !== ex.rdata) begin errors++; $display("FAIL bp_hold_rdata[%0d]: got %h want %h", i, rdata, ex.rdata); end
      if (gnt !== 1'b0)     begin errors++; $display("FAIL bp_hold_gnt[%0d]: got %b want 0", i, gnt); end
    end
    finish_resp();
    checks += 2;
    if (gnt !== 1'b1)    begin errors++; $display("FAIL bp_gnt: got %b want 1", gnt); end
    if (rvalid !== 1'b0) begin errors++; $display("FAIL bp_rvalid: got %b want 0", rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int lat; exp_t ex;
    exp_q.push_back('{rdata: model_rd(32'h20), err: 1'b0});
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex.rdata) begin errors++; $display("FAIL b2b_first: got %h want %h", rd, ex.rdata); end
    req = 1'b1; we = 1'b1; addr = 32'h50; wdata = 32'h0BADF00D; be = 4'hF;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    model_wr(32'h50, 32'h0BADF00D, 4'hF);
    @(posedge clk); #1;
    checks += 2;
    if (gnt !== 1'b1)    begin errors++; $display("FAIL b2b_no_accept: gnt=%b want 1", gnt); end
    if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid: got %b want 0", rvalid); end
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (gnt !== 1'b0) begin errors++; $display("FAIL b2b_accept: gnt=%b want 0", gnt); end
    lat = 0;
    while (rvalid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    ex = exp_q.pop_front();
    checks += 2;
    if (lat != LAT)         begin errors++; $display("FAIL b2b_lat: got %0d want %0d", lat, LAT); end
    if (rdata !== ex.rdata) begin errors++; $display("FAIL b2b_ack: got %h want %h", rdata, ex.rdata); end
    finish_resp();
    exp_q.push_back('{rdata: model_rd(32'h50), err: 1'b0});
    run_txn(1'b0, 32'h50, 32'h0, 4'h0, rd, e, lat);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex.rdata) begin errors++; $display("FAIL b2b_load: got %h want %h", rd, ex.rdata); end
    finish_resp();
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] rd; logic e; int lat; exp_t ex;
    model_wr(32'h30, 32'h0, 4'hF);
    run_txn(1'b1, 32'h30, 32'h0, 4'hF, rd, e, lat);
    finish_resp();
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    checks += 2;
    if (gnt !== 1'b1)    begin errors++; $display("FAIL rstw_gnt: got %b want 1", gnt); end
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rstw_rvalid: got %b want 0", rvalid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{rdata: model_rd(32'h30), err: 1'b0});
    run_txn(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex.rdata) begin errors++; $display("FAIL rstw_load: got %h want %h", rd, ex.rdata); end
    finish_resp();
    rready = 1'b0;
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    rst = 1'b0;
    #2;
    checks += 2;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rstr_rvalid: got %b want 0", rvalid); end
    if (rdata !== 32'h0) begin errors++; $display("FAIL rstr_rdata: got %h want 0", rdata); end
    @(posedge clk); #1;
    rst = 1'b1;
    rready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_align();
    logic [31:0] rd; logic e; int lat; exp_t ex;
    model_wr(32'h40, 32'h55AA55AA, 4'hF);
    run_txn(1'b1, 32'h40, 32'h55AA55AA, 4'hF, rd, e, lat);
    finish_resp();
`ifdef DM_ALIGN_CHECK_EN
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
`else
    exp_q.push_back('{rdata: model_rd(32'h12), err: 1'b0});
`endif
    run_txn(1'b0, 32'h12, 32'h0, 4'h0, rd, e, lat);
    ex = exp_q.pop_front();
    checks += 3;
    if (lat != LAT)      begin errors++; $display("FAIL al_load_lat: got %0d want %0d", lat, LAT); end
    if (rd !== ex.rdata) begin errors++; $display("FAIL al_load_rdata: got %h want %h", rd, ex.rdata); end
    if (e !== ex.err)    begin errors++; $display("FAIL al_load_err: got %b want %b", e, ex.err); end
    finish_resp();
`ifdef DM_ALIGN_CHECK_EN
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
`else
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    model_wr(32'h41, 32'hFFFFFFFF, 4'hF);
`endif
    run_txn(1'b1, 32'h41, 32'hFFFFFFFF, 4'hF, rd, e, lat);
    ex = exp_q.pop_front();
    checks += 2;
    if (rd !== ex.rdata) begin errors++; $display("FAIL al_store_rdata: got %h want %h", rd, ex.rdata); end
    if (e !== ex.err)    begin errors++; $display("FAIL al_store_err: got %b want %b", e, ex.err); end
    finish_resp();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL al_err_clear: got %b want 0", err); end
    exp_q.push_back('{rdata: model_rd(32'h40), err: 1'b0});
    run_txn(1'b0, 32'h40, 32'h0, 4'h0, rd, e, lat);
    ex = exp_q.pop_front();
    checks += 2;
    if (rd !== ex.rdata) begin errors++; $display("FAIL al_word40: got %h want %h", rd, ex.rdata); end
    if (e !== ex.err)    begin errors++; $display("FAIL al_word40_err: got %b want %b", e, ex.err); end
    finish_resp();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_addr_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_store();
    test_align();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
